nanov_sequencer: RTL and testbench
==================================

# nanov_sequencer

Instruction sequencer for the bit-serial nanoV core. It generates the `counter`/`cycle` timebase and collects the serial instruction stream into a prefetch buffer. It presents `instr`/`next_instr` to the core, decides how many 32-clock cycles each instruction occupies, and drives the memory data-shift window. When no complete instruction is available, it inserts NOP bubbles so the core never stalls its clock.

## Interface
Parameters:
- `NOP_INSTR`, 32'h00000013: bubble instruction (`addi x0,x0,0`).

Ports:
- `clk`  in  1  core clock; everything registered on rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `fetch_bit`  in  1  serial instruction bit, LSB first.
- `fetch_valid`  in  1  `fetch_bit` qualifier.
- `fetch_ready`  out  1  buffer accepts a bit this clock.
- `fetch_restart`  out  1  one-clock pulse: discard stream, refetch from new PC.
- `branch`  in  1  core branch/jump-taken indication.
- `instr`  out  32  current instruction.
- `next_instr`  out  31  bits [30:0] of the following instruction.
- `cycle`  out  3  cycle index within instruction (0..2).
- `counter`  out  5  bit index within cycle (0..31).
- `shift_data_out`  out  1  memory data window active.
- `mem_start`  out  1  one-clock pulse at start of data window.

## Operation
- Counter: increments every clock and wraps 31→0. At the wrap, `cycle` advances, or the instruction retires if this was its last cycle.
- Cycle count per instruction, decoded from `instr`:
  - OP/OP-IMM/LUI/AUIPC: 1. Shifts (funct3 = 001/101 with OP/OP-IMM) are the exception: 2.
  - JAL/JALR: 2.
  - Branch: 1 if not taken, 2 if `branch` is high at cycle 0, counter 31.
  - Store: 2.
  - Load: 3.
- Memory window: `shift_data_out`=1 for all of cycle 1 of a load or store. `mem_start`=1 at cycle 1, counter 0.
- Prefetch buffer: 32-bit shift register plus 6-bit fill count (0..32).
  - `fetch_ready` = fill<32, or (fill==32 and retire this clock).
  - A bit is accepted when `fetch_valid && fetch_ready`. It enters at position `fill`, and fill increments.
- Retire (last clock of last cycle):
  - If fill==32, or fill==31 with a bit accepted this clock: `instr` ← buffered word (bit 31 may be the incoming bit), and the buffer empties. A bit accepted in the same clock as a full-buffer retire becomes bit 0 of the new buffer.
  - Otherwise: `instr` ← `NOP_INSTR`, and the buffer keeps its partial contents.
- `next_instr`: buffer[30:0] when fill≥31, else `NOP_INSTR[30:0]`. Valid at retire for rs1/rs2 lookahead.
- `branch` handling:
  - Sampled only at cycle 0 with counter 0 (jumps) or counter 31 (branches); ignored otherwise.
  - When taken: `fetch_restart` pulses the next clock, the buffer is cleared (fill←0), and the remaining cycles of the current instruction still run.
  - Bits presented during the restart-pulse clock are dropped.
- Reset:
  - `instr`=`NOP_INSTR`, counter=0, cycle=0, fill=0.
  - `fetch_restart`=1 for the first clock after reset release; all other outputs 0.
  - Reset mid-instruction or mid-window aborts immediately; no retire occurs.

## Timing
- `counter`/`cycle` are registered; they change only on the clock edge.
- Minimum bubble-free throughput: one bit per clock sustained during any 32-clock span.
- `branch` to `fetch_restart`: 1 clock.
- `fetch_ready` is combinational from fill and retire.
- `instr` changes only at the counter 31→0 boundary of a retire.

## Configuration
- `NANOV_SEQ_BUBBLE_COUNT_EN`:
  - Defined: adds output `bubble_count` [15:0]. It increments on each NOP-inserting retire, saturates at 16'hFFFF, and is 0 on reset.
  - Undefined: the port and counter are absent, and behaviour is otherwise identical.

## Test plan
- Continuous stream of `addi x1,x0,5` (0x00500093) from reset: first retire after 32 clocks loads a NOP (fill 31 at reset retire) or the word. Every following instruction lasts exactly 32 clocks, `cycle` stays 0, no NOP after the first.
- Stream `lw x2,0(x1)`: cycle runs 0,1,2 (96 clocks). `shift_data_out`=1 for clocks 32..63 only. `mem_start` pulses at clock 32.
- `beq` with `branch`=0 at counter 31 → 1 cycle, buffer retained. With `branch`=1 → 2 cycles, `fetch_restart` pulse next clock, fill=0, next retire loads NOP.
- `fetch_valid` low for 40 clocks mid-stream → exactly one or two NOP retires, `fetch_ready` stays 1 while fill<32. Stream resumes with no lost or duplicated bits.
- Buffer full while a 3-cycle load executes → `fetch_ready`=0 until the retire clock, then accepted bit lands at buffer bit 0.
- Assert `rst` at cycle 1 counter 10 of a load → next clock: counter=0, cycle=0, `shift_data_out`=0, `instr`=0x00000013. With `NANOV_SEQ_BUBBLE_COUNT_EN`, `bubble_count`=0.

Source files
------------

// File: rtl/nanov_sequencer.sv
// nanov_sequencer
//   Instruction sequencer for the bit-serial nanoV core. Generates the
//   counter/cycle timebase, collects the serial instruction stream into a
//   32-bit prefetch buffer, presents instr/next_instr to the core, sets how
//   many 32-clock cycles each instruction occupies and drives the memory
//   data-shift window. NOP bubbles are inserted when no complete word is ready.
//
// Ports
//   clk            core clock, all state on rising edge
//   rst            synchronous active-high reset
//   fetch_bit      serial instruction bit, LSB first
//   fetch_valid    fetch_bit qualifier
//   fetch_ready    buffer accepts a bit this clock (combinational)
//   fetch_restart  one-clock pulse: discard stream, refetch from new PC
//   branch         branch/jump-taken indication from the core
//   instr          current instruction
//   next_instr     bits [30:0] of the following instruction
//   cycle          cycle index within the instruction (0..2)
//   counter        bit index within the cycle (0..31)
//   shift_data_out memory data window active
//   mem_start      one-clock pulse at the start of the data window
//   bubble_count   (NANOV_SEQ_BUBBLE_COUNT_EN only) saturating NOP-retire count
//
// Configuration macro: NANOV_SEQ_BUBBLE_COUNT_EN

module nanov_sequencer #(
    parameter logic [31:0] NOP_INSTR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch_bit,
    input  logic        fetch_valid,
    output logic        fetch_ready,
    output logic        fetch_restart,
    input  logic        branch,
    output logic [31:0] instr,
    output logic [30:0] next_instr,
    output logic [2:0]  cycle,
    output logic [4:0]  counter,
    output logic        shift_data_out,
    output logic        mem_start
`ifdef NANOV_SEQ_BUBBLE_COUNT_EN
    ,
    output logic [15:0] bubble_count
`endif
);

    typedef enum logic [1:0] {
        CYC_0 = 2'd0,
        CYC_1 = 2'd1,
        CYC_2 = 2'd2
    } cyc_e;

    cyc_e        cyc_q;
    cyc_e        cyc_d;
    logic [31:0] buf_q;
    logic [5:0]  fill_q;
    logic        taken_q;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_op, is_opimm, is_lui, is_auipc;
    logic        is_jal, is_jalr, is_branch, is_store, is_load;
    logic        is_shift, is_mem;
    logic        branch_take, jump_take, take;
    logic        last_cycle, retire, accept;
    logic        buf_full;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];

    assign is_op     = (opcode == 7'b0110011);
    assign is_opimm  = (opcode == 7'b0010011);
    assign is_lui    = (opcode == 7'b0110111);
    assign is_auipc  = (opcode == 7'b0010111);
    assign is_jal    = (opcode == 7'b1101111);
    assign is_jalr   = (opcode == 7'b1100111);
    assign is_branch = (opcode == 7'b1100011);
    assign is_store  = (opcode == 7'b0100011);
    assign is_load   = (opcode == 7'b0000011);
    assign is_shift  = (is_op || is_opimm) && (funct3[1:0] == 2'b01);
    assign is_mem    = is_load || is_store;

    // Branches resolve at the last clock of cycle 0, jumps at its first clock.
    assign branch_take = is_branch && (cyc_q == CYC_0) && (counter == 5'd31) && branch;
    assign jump_take   = (is_jal || is_jalr) && (cyc_q == CYC_0) && (counter == 5'd0) && branch;
    assign take        = branch_take || jump_take;

    always_comb begin
        last_cycle = (cyc_q == CYC_0);
        if (is_load) begin
            last_cycle = (cyc_q == CYC_2);
        end else if (is_store || is_jal || is_jalr || is_shift) begin
            last_cycle = (cyc_q == CYC_1);
        end else if (is_branch) begin
            // A branch taken in this very clock extends to a second cycle.
            last_cycle = (taken_q || branch_take) ? (cyc_q == CYC_1) : (cyc_q == CYC_0);
        end else if (is_lui || is_auipc) begin
            last_cycle = (cyc_q == CYC_0);
        end
    end

    assign retire      = (counter == 5'd31) && last_cycle;
    assign buf_full    = (fill_q == 6'd32);
    assign fetch_ready = !buf_full || retire;
    // Bits offered while the restart pulse is out belong to the old stream.
    assign accept      = fetch_valid && fetch_ready && !fetch_restart;

    assign next_instr = (fill_q >= 6'd31) ? buf_q[30:0] : NOP_INSTR[30:0];
    assign cycle      = {1'b0, cyc_q};

    always_comb begin
        cyc_d = cyc_q;
        if (counter == 5'd31) begin
            if (retire) begin
                cyc_d = CYC_0;
            end else begin
                case (cyc_q)
                    CYC_0:   cyc_d = CYC_1;
                    CYC_1:   cyc_d = CYC_2;
                    default: cyc_d = CYC_0;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            counter        <= '0;
            cyc_q          <= CYC_0;
            buf_q          <= '0;
            fill_q         <= '0;
            taken_q        <= 1'b0;
            instr          <= NOP_INSTR;
            fetch_restart  <= 1'b1;
            shift_data_out <= 1'b0;
            mem_start      <= 1'b0;
`ifdef NANOV_SEQ_BUBBLE_COUNT_EN
            bubble_count   <= '0;
`endif
        end else begin
            counter       <= counter + 5'd1;
            cyc_q         <= cyc_d;
            fetch_restart <= take;

            if (retire) begin
                taken_q <= 1'b0;
            end else if (branch_take) begin
                taken_q <= 1'b1;
            end

            // instr only changes at retire, where cyc_d is CYC_0, so the
            // current decode is valid for the next-state window flags.
            shift_data_out <= is_mem && (cyc_d == CYC_1);
            mem_start      <= is_mem && (cyc_d == CYC_1) && (cyc_q == CYC_0);

            // take and retire are never asserted in the same clock.
            if (take) begin
                fill_q <= '0;
            end else if (retire && buf_full) begin
                instr <= buf_q;
                if (accept) begin
                    buf_q[0] <= fetch_bit;
                    fill_q   <= 6'd1;
                end else begin
                    fill_q   <= '0;
                end
            end else if (retire && (fill_q == 6'd31) && accept) begin
                instr  <= {fetch_bit, buf_q[30:0]};
                fill_q <= '0;
            end else begin
                if (retire) begin
                    instr <= NOP_INSTR;
`ifdef NANOV_SEQ_BUBBLE_COUNT_EN
                    if (bubble_count != 16'hFFFF) begin
                        bubble_count <= bubble_count + 16'd1;
                    end
`endif
                end
                if (accept) begin
                    buf_q[fill_q[4:0]] <= fetch_bit;
                    fill_q             <= fill_q + 6'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_nanov_sequencer.sv
module tb_nanov_sequencer;

    localparam logic [31:0] NOP  = 32'h00000013;
    localparam logic [31:0] ADDI = 32'h00500093;
    localparam logic [31:0] LW   = 32'h0000A103;
    localparam logic [31:0] BEQ  = 32'h00000063;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_bit;
    logic        fetch_valid;
    logic        fetch_ready;
    logic        fetch_restart;
    logic        branch;
    logic [31:0] instr;
    logic [30:0] next_instr;
    logic [2:0]  cycle;
    logic [4:0]  counter;
    logic        shift_data_out;
    logic        mem_start;
`ifdef NANOV_SEQ_BUBBLE_COUNT_EN
    logic [15:0] bubble_count;
`endif

    nanov_sequencer #(.NOP_INSTR(32'h00000013)) dut (
        .clk            (clk),
        .rst            (rst),
        .fetch_bit      (fetch_bit),
        .fetch_valid    (fetch_valid),
        .fetch_ready    (fetch_ready),
        .fetch_restart  (fetch_restart),
        .branch         (branch),
        .instr          (instr),
        .next_instr     (next_instr),
        .cycle          (cycle),
        .counter        (counter),
        .shift_data_out (shift_data_out),
        .mem_start      (mem_start)
`ifdef NANOV_SEQ_BUBBLE_COUNT_EN
        ,
        .bubble_count   (bubble_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned total = 0;
    int unsigned bad   = 0;
    logic [31:0] stream_words [0:63];
    int unsigned idx;
    logic        valid_en;

    typedef struct {
        logic [31:0] word;
        int unsigned clks;
        int unsigned win_clks;
        int unsigned starts;
        int unsigned first_win;
    } vec_t;

    vec_t tab [0:10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic get_bit(input int unsigned i);
        logic [31:0] w;
        w = stream_words[(i >> 5) % 64];
        return w[i % 32];
    endfunction

    // Stream source: advances only on a handshake the sequencer actually takes.
    task automatic step();
        logic acc;
        fetch_bit   = get_bit(idx);
        fetch_valid = valid_en;
        #3;
        acc = fetch_valid && fetch_ready && !fetch_restart && !rst;
        @(posedge clk);
        #1;
        if (acc) idx++;
    endtask

    task automatic fill_stream(input logic [31:0] a, input logic [31:0] b);
        for (int unsigned i = 0; i < 64; i++) stream_words[i] = (i % 2 == 0) ? a : b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        branch = 1'b0;
        valid_en = 1'b1;
        idx = 0;
        repeat (3) step();
        rst = 1'b0;
        idx = 0;
    endtask

    task automatic wait_instr(input string name, input logic [31:0] w, input int unsigned max);
        int unsigned n;
        n = 0;
        while (!(instr == w && counter == 5'd0) && n < max) begin
            step();
            n++;
        end
        chk(name, instr, w);
    endtask

    initial begin
        int unsigned n, win, starts, first, nops, k;
        logic [31:0] w;

        tab[0]  = '{32'h00500093, 32,  0, 0, 255};  // addi
        tab[1]  = '{32'h002081B3, 32,  0, 0, 255};  // add
        tab[2]  = '{32'h00309093, 64,  0, 0, 255};  // slli
        tab[3]  = '{32'h0020D1B3, 64,  0, 0, 255};  // srl
        tab[4]  = '{32'h123452B7, 32,  0, 0, 255};  // lui
        tab[5]  = '{32'h00000297, 32,  0, 0, 255};  // auipc
        tab[6]  = '{32'h000000EF, 64,  0, 0, 255};  // jal
        tab[7]  = '{32'h00008067, 64,  0, 0, 255};  // jalr
        tab[8]  = '{32'h0020A023, 64, 32, 1, 32};   // sw
        tab[9]  = '{32'h0000A103, 96, 32, 1, 32};   // lw
        tab[10] = '{32'h00000063, 32,  0, 0, 255};  // beq not taken

        fetch_bit = 1'b0;
        fetch_valid = 1'b0;

        // Reset state and the first restart clock
        fill_stream(ADDI, ADDI);
        do_reset();
        chk("rst_counter", {27'd0, counter}, 32'd0);
        chk("rst_cycle", {29'd0, cycle}, 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_restart", {31'd0, fetch_restart}, 32'd1);
        chk("rst_sdo", {31'd0, shift_data_out}, 32'd0);
        chk("rst_memstart", {31'd0, mem_start}, 32'd0);
`ifdef NANOV_SEQ_BUBBLE_COUNT_EN
        chk("rst_bubble", {16'd0, bubble_count}, 32'd0);
`endif
        step();
        chk("restart_cleared", {31'd0, fetch_restart}, 32'd0);
        chk("counter_one", {27'd0, counter}, 32'd1);

        // Continuous addi: first retire is a bubble, the second loads the word
        repeat (31) step();
        chk("first_retire_nop", instr, NOP);
        chk("first_retire_cnt", {27'd0, counter}, 32'd0);
        repeat (32) step();
        chk("second_retire_word", instr, ADDI);
        nops = 0;
        for (int unsigned c = 0; c < 96; c++) begin
            step();
            if (cycle != 3'd0 || instr != ADDI) nops++;
        end
        chk("addi_steady", nops, 32'd0);

        // Table: cycle count and memory window per instruction class
        for (int unsigned i = 0; i < 11; i++) begin
            fill_stream(tab[i].word, tab[i].word);
            do_reset();
            wait_instr($sformatf("v%0d_load", i), tab[i].word, 200);
            n = 0; win = 0; starts = 0; first = 255;
            do begin
                if (shift_data_out) begin
                    win++;
                    if (first == 255) first = n;
                end
                if (mem_start) starts++;
                step();
                n++;
            end while (!(counter == 5'd0 && cycle == 3'd0) && n < 200);
            chk($sformatf("v%0d_clks", i), n, tab[i].clks);
            chk($sformatf("v%0d_win", i), win, tab[i].win_clks);
            chk($sformatf("v%0d_start", i), starts, tab[i].starts);
            chk($sformatf("v%0d_first", i), first, tab[i].first_win);
        end

        // Full buffer during a load; the bit taken at retire starts the next word
        fill_stream(LW, ADDI);
        do_reset();
        wait_instr("full_lw_load", LW, 200);
        repeat (74) step();
        chk("full_cycle2", {29'd0, cycle}, 32'd2);
        chk("full_not_ready", {31'd0, fetch_ready}, 32'd0);
        chk("full_next", {1'b0, next_instr}, {1'b0, ADDI[30:0]});
        repeat (21) step();
        chk("full_retire_ready", {31'd0, fetch_ready}, 32'd1);
        step();
        chk("full_next_word", instr, ADDI);
        repeat (32) step();
        chk("full_bit0_aligned", instr, LW);

        // Taken branch: restart pulse, two cycles, bubble, then refetched word
        fill_stream(BEQ, BEQ);
        do_reset();
        wait_instr("br_load", BEQ, 200);
        repeat (31) step();
        branch = 1'b1;
        step();
        branch = 1'b0;
        idx = 0;
        chk("br_restart", {31'd0, fetch_restart}, 32'd1);
        chk("br_cycle1", {29'd0, cycle}, 32'd1);
        repeat (32) step();
        chk("br_restart_gone", {31'd0, fetch_restart}, 32'd0);
        chk("br_end_cycle", {29'd0, cycle}, 32'd0);
        chk("br_nop", instr, NOP);
        repeat (32) step();
        chk("br_refetch", instr, BEQ);

        // Starved fetch: a few bubbles, no lost or duplicated words
        for (int unsigned i = 0; i < 64; i++) stream_words[i] = 32'h00000093 | (i << 20);
        do_reset();
        wait_instr("starve_load", stream_words[0], 200);
        nops = 0; k = 1;
        for (int unsigned c = 0; c < 450; c++) begin
            valid_en = !(c >= 10 && c < 50);
            if (!valid_en) chk("starve_ready", {31'd0, fetch_ready}, 32'd1);
            step();
            if (counter == 5'd0) begin
                if (instr == NOP) nops++;
                else begin
                    w = stream_words[k];
                    chk("starve_order", instr, w);
                    k++;
                end
            end
        end
        valid_en = 1'b1;
        chk("starve_bubbles_ok", {31'd0, (nops >= 1 && nops <= 2)}, 32'd1);
        chk("starve_words", {31'd0, (k >= 10)}, 32'd1);
`ifdef NANOV_SEQ_BUBBLE_COUNT_EN
        chk("starve_bubble_cnt", {16'd0, bubble_count}, 1 + nops);
`endif

        // Reset in the middle of a load's data window
        fill_stream(LW, LW);
        do_reset();
        wait_instr("rmid_load", LW, 200);
        repeat (42) step();
        chk("rmid_cycle", {29'd0, cycle}, 32'd1);
        chk("rmid_counter", {27'd0, counter}, 32'd10);
        chk("rmid_sdo_on", {31'd0, shift_data_out}, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rmid_counter0", {27'd0, counter}, 32'd0);
        chk("rmid_cycle0", {29'd0, cycle}, 32'd0);
        chk("rmid_sdo_off", {31'd0, shift_data_out}, 32'd0);
        chk("rmid_instr", instr, NOP);
`ifdef NANOV_SEQ_BUBBLE_COUNT_EN
        chk("rmid_bubble", {16'd0, bubble_count}, 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
